// File: rtl/plank_fdbck_frame_tx_if.sv
// Request/status bundle between a plank feedback frame transmitter and whatever starts it.
interface plank_fdbck_frame_tx_if;
  logic         start;
  logic [2:0]   module_id;
  logic [135:0] payload;
  logic         tx_serial;
  logic         tx_active;
  logic         busy;
  logic         done;
  logic [4:0]   byte_idx;

  modport master (
    output start, module_id, payload,
    input  tx_serial, tx_active, busy, done, byte_idx
  );

  modport slave (
    input  start, module_id, payload,
    output tx_serial, tx_active, busy, done, byte_idx
  );
endinterface

// File: rtl/plank_fdbck_frame_tx.sv
// Plank feedback frame transmitter: builds the 22-byte feedback frame (header, type, payload,
// id, XOR checksum, footer) and sends it as 8N1 UART, LSB first, on a start request.
module plank_fdbck_frame_tx #(
  parameter int CLKS_PER_BIT = 868,
  parameter int GAP_BITS     = 0
) (
  input logic                   clk,
  input logic                   rst_n,
  plank_fdbck_frame_tx_if.slave bus
);

  localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int GW = (GAP_BITS > 1) ? $clog2(GAP_BITS) : 1;
  localparam logic [CW-1:0] CLK_LAST = CW'(CLKS_PER_BIT - 1);
  localparam logic [GW-1:0] GAP_LAST = GW'((GAP_BITS > 0) ? GAP_BITS - 1 : 0);
  localparam bit HAS_GAP = (GAP_BITS > 0);

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    START,
    DATA,
    STOP,
    GAP,
    DONE
  } state_t;

  state_t         state;
  state_t         state_nx;
  logic [135:0]   payload_q;
  logic [2:0]     id_q;
  logic [7:0]     chk_q;
  logic [7:0]     shift_q;
  logic [4:0]     idx_q;
  logic [CW-1:0]  clk_cnt;
  logic [2:0]     bit_cnt;
  logic [GW-1:0]  gap_cnt;

  logic           bit_end;
  logic           accept;
  logic           load_en;
  logic           adv_idx;
  logic [4:0]     load_idx;
  logic [7:0]     load_byte;

  assign bit_end = (clk_cnt == CLK_LAST);

  // Byte selector for the frame position being loaded; position 20 is the running checksum.
  always_comb begin
    case (load_idx)
      5'd0:    load_byte = 8'hAA;
      5'd1:    load_byte = 8'hE2;
      5'd19:   load_byte = {5'd0, id_q};
      5'd20:   load_byte = chk_q;
      5'd21:   load_byte = 8'h55;
      default: load_byte = payload_q[{load_idx - 5'd2, 3'b000} +: 8];
    endcase
  end

  // Only the first byte gets a LOAD cycle; later bytes are loaded on the last stop/gap clock
  // so every bit and gap lasts exactly its nominal number of clocks.
  always_comb begin
    state_nx = state;
    accept   = 1'b0;
    load_en  = 1'b0;
    adv_idx  = 1'b0;
    load_idx = idx_q;
    case (state)
      IDLE: begin
        if (bus.start) begin
          accept   = 1'b1;
          state_nx = LOAD;
        end
      end
      LOAD: begin
        load_en  = 1'b1;
        state_nx = START;
      end
      START: begin
        if (bit_end) state_nx = DATA;
      end
      DATA: begin
        if (bit_end && bit_cnt == 3'd7) state_nx = STOP;
      end
      STOP: begin
        if (bit_end) begin
          if (idx_q == 5'd21) begin
            state_nx = DONE;
          end else begin
            adv_idx = 1'b1;
            if (HAS_GAP) begin
              state_nx = GAP;
            end else begin
              load_en  = 1'b1;
              load_idx = idx_q + 5'd1;
              state_nx = START;
            end
          end
        end
      end
      GAP: begin
        if (bit_end && gap_cnt == GAP_LAST) begin
          load_en  = 1'b1;
          state_nx = START;
        end
      end
      DONE: begin
        state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      payload_q <= '0;
      id_q      <= '0;
      chk_q     <= '0;
      shift_q   <= '0;
      idx_q     <= '0;
      clk_cnt   <= '0;
      bit_cnt   <= '0;
      gap_cnt   <= '0;
    end else begin
      state <= state_nx;
      if (accept) begin
        payload_q <= bus.payload;
        id_q      <= bus.module_id;
        chk_q     <= '0;
        idx_q     <= '0;
      end
      if (load_en) begin
        shift_q <= load_byte;
        bit_cnt <= '0;
        if (load_idx < 5'd20) chk_q <= chk_q ^ load_byte;
      end else if (state == DATA && bit_end) begin
        shift_q <= shift_q >> 1;
        bit_cnt <= bit_cnt + 3'd1;
      end
      if (adv_idx) idx_q <= idx_q + 5'd1;
      if (state == START || state == DATA || state == STOP || state == GAP) begin
        clk_cnt <= bit_end ? '0 : clk_cnt + CW'(1);
      end else begin
        clk_cnt <= '0;
      end
      if (state == GAP) begin
        if (bit_end) gap_cnt <= gap_cnt + GW'(1);
      end else begin
        gap_cnt <= '0;
      end
    end
  end

  assign bus.tx_serial = (state == START) ? 1'b0 : (state == DATA) ? shift_q[0] : 1'b1;
  assign bus.tx_active = (state == START) || (state == DATA) || (state == STOP);
  assign bus.busy      = (state != IDLE) && (state != DONE);
  assign bus.done      = (state == DONE);
  assign bus.byte_idx  = ((state == IDLE) || (state == DONE)) ? 5'd0 : idx_q;

endmodule

// File: tb/tb_plank_fdbck_frame_tx.sv
// Bench for plank_fdbck_frame_tx: UART receivers decode both DUT lines and frames are
// compared against a byte-level frame model built from the payload and id.
module tb_plank_fdbck_frame_tx;

  localparam int C   = 8;
  localparam int GAP = 2;

  logic        clk   = 1'b0;
  logic        rst_n = 1'b0;
  int unsigned cyc   = 0;
  int          tests = 0;
  int          fails = 0;

  logic [8:0]  rx0[$];
  logic [8:0]  rx1[$];
  int unsigned fall0[$];
  int unsigned fall1[$];
  logic [7:0]  exp_frame [22];

  plank_fdbck_frame_tx_if bus0 ();
  plank_fdbck_frame_tx_if bus1 ();

  plank_fdbck_frame_tx #(.CLKS_PER_BIT(C), .GAP_BITS(0)) dut0 (
    .clk(clk), .rst_n(rst_n), .bus(bus0)
  );

  plank_fdbck_frame_tx #(.CLKS_PER_BIT(C), .GAP_BITS(GAP)) dut1 (
    .clk(clk), .rst_n(rst_n), .bus(bus1)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic line_of(input int w);
    return (w == 0) ? bus0.tx_serial : bus1.tx_serial;
  endfunction

  function automatic logic done_of(input int w);
    return (w == 0) ? bus0.done : bus1.done;
  endfunction

  function automatic logic [135:0] rand_payload();
    logic [135:0] p;
    for (int k = 0; k < 17; k++) p[8*k +: 8] = 8'($urandom_range(0, 255));
    return p;
  endfunction

  task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Mid-bit sampling receiver; each entry is {stop_bit, data_byte}.
  task automatic uart_rx(input int w);
    logic       prev;
    logic [7:0] b;
    logic       stop;
    prev = 1'b1;
    forever begin
      @(negedge clk);
      if (prev && !line_of(w)) begin
        if (w == 0) fall0.push_back(cyc); else fall1.push_back(cyc);
        repeat (C / 2) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
          repeat (C) @(negedge clk);
          b[i] = line_of(w);
        end
        repeat (C) @(negedge clk);
        stop = line_of(w);
        if (w == 0) rx0.push_back({stop, b}); else rx1.push_back({stop, b});
      end
      prev = line_of(w);
    end
  endtask

  initial uart_rx(0);
  initial uart_rx(1);

  task automatic build_expected(input logic [135:0] pl, input logic [2:0] id);
    logic [7:0] x;
    exp_frame[0] = 8'hAA;
    exp_frame[1] = 8'hE2;
    for (int k = 0; k < 17; k++) exp_frame[k + 2] = pl[8*k +: 8];
    exp_frame[19] = {5'd0, id};
    x = 8'h00;
    for (int i = 0; i < 20; i++) x = x ^ exp_frame[i];
    exp_frame[20] = x;
    exp_frame[21] = 8'h55;
  endtask

  task automatic check_frame(input string tag, input int w, input logic [135:0] pl,
                             input logic [2:0] id);
    int unsigned period;
    int          n;
    build_expected(pl, id);
    period = (w == 0) ? 10 * C : (10 + GAP) * C;
    n = (w == 0) ? rx0.size() : rx1.size();
    check_output({tag, "_len"}, n, 22);
    for (int i = 0; i < 22 && i < n; i++) begin
      check_output($sformatf("%s_byte%0d", tag, i), (w == 0) ? rx0[i] : rx1[i],
                   {23'd0, 1'b1, exp_frame[i]});
    end
    for (int i = 1; i < n; i++) begin
      check_output($sformatf("%s_spacing%0d", tag, i),
                   (w == 0) ? fall0[i] - fall0[i-1] : fall1[i] - fall1[i-1], period);
    end
    rx0.delete(); rx1.delete(); fall0.delete(); fall1.delete();
  endtask

  // Call at a negedge; start is high for exactly one rising edge, e is that edge's number.
  task automatic apply_stimulus(input int w, input logic [135:0] pl, input logic [2:0] id,
                                output int unsigned e);
    if (w == 0) begin
      bus0.payload = pl; bus0.module_id = id; bus0.start = 1'b1;
    end else begin
      bus1.payload = pl; bus1.module_id = id; bus1.start = 1'b1;
    end
    @(negedge clk);
    bus0.start = 1'b0;
    bus1.start = 1'b0;
    e = cyc;
  endtask

  task automatic wait_done(input int w, input string tag, input int budget, output int unsigned d);
    logic found;
    found = 1'b0;
    d = 0;
    for (int i = 0; i < budget && !found; i++) begin
      @(negedge clk);
      if (done_of(w)) begin
        found = 1'b1;
        d = cyc;
      end
    end
    check_output({tag, "_done_seen"}, found, 1);
  endtask

  task automatic wait_until(input int unsigned target);
    while (cyc < target) @(negedge clk);
  endtask

  initial begin
    logic [135:0] pl_a;
    logic [135:0] pl_r;
    logic [2:0]   id_r;
    int unsigned  e;
    int unsigned  d;
    logic         seen;

    bus0.start = 1'b0; bus0.payload = '0; bus0.module_id = '0;
    bus1.start = 1'b0; bus1.payload = '0; bus1.module_id = '0;
    pl_a = {17{8'h32}};

    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    check_output("rst_tx0", bus0.tx_serial, 1);
    check_output("rst_active0", bus0.tx_active, 0);
    check_output("rst_busy0", bus0.busy, 0);
    check_output("rst_done0", bus0.done, 0);
    check_output("rst_idx0", bus0.byte_idx, 0);
    check_output("rst_tx1", bus1.tx_serial, 1);
    check_output("rst_busy1", bus1.busy, 0);
    rst_n = 1'b1;
    @(negedge clk);

    // Frame A: fixed payload, id 0, with latency, byte index and ignored re-start checks
    apply_stimulus(0, pl_a, 3'd0, e);
    check_output("A_busy_after_accept", bus0.busy, 1);
    check_output("A_tx_still_idle", bus0.tx_serial, 1);
    check_output("A_active_in_load", bus0.tx_active, 0);
    @(negedge clk);
    check_output("A_start_bit", bus0.tx_serial, 0);
    check_output("A_active_start", bus0.tx_active, 1);
    wait_until(e + 1 + 70 * C + 5);
    check_output("A_byte_idx7", bus0.byte_idx, 7);
    bus0.payload = rand_payload();
    bus0.module_id = 3'd6;
    bus0.start = 1'b1;
    @(negedge clk);
    bus0.start = 1'b0;
    wait_done(0, "A", 30 * 10 * C, d);
    check_output("A_done_latency", d - e, 1 + 220 * C);
    check_output("A_busy_in_done", bus0.busy, 0);
    check_output("A_idx_in_done", bus0.byte_idx, 0);
    check_output("A_chk_byte", (rx0.size() > 20) ? rx0[20] : 9'h0, 9'h17A);
    check_frame("A", 0, pl_a, 3'd0);

    // Start raised during the DONE cycle is dropped
    bus0.start = 1'b1;
    @(negedge clk);
    bus0.start = 1'b0;
    check_output("done_start_ignored_busy", bus0.busy, 0);
    check_output("done_pulse_one_cycle", bus0.done, 0);

    // Frame B: accepted in the IDLE cycle right after DONE, id 5
    apply_stimulus(0, pl_a, 3'd5, e);
    check_output("B_busy", bus0.busy, 1);
    wait_done(0, "B", 30 * 10 * C, d);
    check_output("B_chk_byte", (rx0.size() > 20) ? rx0[20] : 9'h0, 9'h17F);
    check_frame("B", 0, pl_a, 3'd5);

    // Frame C: random content, inputs scrambled after accept
    @(negedge clk);
    pl_r = rand_payload();
    id_r = 3'($urandom_range(0, 7));
    apply_stimulus(0, pl_r, id_r, e);
    bus0.payload = ~pl_r;
    bus0.module_id = ~id_r;
    wait_done(0, "C", 30 * 10 * C, d);
    check_output("C_done_latency", d - e, 1 + 220 * C);
    check_frame("C", 0, pl_r, id_r);

    // Frame D: reset during byte 10 data bits aborts without done
    @(negedge clk);
    apply_stimulus(0, rand_payload(), 3'd2, e);
    wait_until(e + 1 + 100 * C + 4 * C);
    check_output("D_idx10", bus0.byte_idx, 10);
    rst_n = 1'b0;
    @(negedge clk);
    check_output("D_abort_tx_high", bus0.tx_serial, 1);
    check_output("D_abort_busy", bus0.busy, 0);
    check_output("D_abort_active", bus0.tx_active, 0);
    rst_n = 1'b1;
    seen = 1'b0;
    repeat (12 * C) begin
      @(negedge clk);
      if (bus0.done) seen = 1'b1;
    end
    check_output("D_no_done", seen, 0);
    rx0.delete(); fall0.delete();

    // Frame E: fresh random frame after the abort
    pl_r = rand_payload();
    id_r = 3'($urandom_range(0, 7));
    apply_stimulus(0, pl_r, id_r, e);
    wait_done(0, "E", 30 * 10 * C, d);
    check_frame("E", 0, pl_r, id_r);

    // Gap build: same content, two idle bit-times between bytes
    @(negedge clk);
    apply_stimulus(1, pl_a, 3'd5, e);
    wait_done(1, "G", 30 * 12 * C, d);
    check_output("G_done_latency", d - e, 1 + 220 * C + 21 * GAP * C);
    check_frame("G", 1, pl_a, 3'd5);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
